// File: rtl/tipi_regs_pkg.sv
// tipi_regs_pkg: shared constants, FSM state type and select-decode helper
// for the TI-bus write latch.
//   NUM_REGS        number of latched registers (a..d)
//   REG_A..REG_D    bit/array index of each register in select, wr, pending
//   wr_state_t      write-capture FSM states
//   count_sel()     number of asserted select bits
package tipi_regs_pkg;

  localparam int unsigned NUM_REGS = 4;
  localparam int unsigned REG_A    = 0;
  localparam int unsigned REG_B    = 1;
  localparam int unsigned REG_C    = 2;
  localparam int unsigned REG_D    = 3;

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    COMMIT
  } wr_state_t;

  function automatic int unsigned count_sel(input logic [NUM_REGS-1:0] sel);
    int unsigned n;
    n = 0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (sel[i]) n++;
    end
    return n;
  endfunction

endpackage

// File: rtl/tipi_bus_write_latch_sync_bus.sv
// sync_bus: N-bit, STAGES-deep flip-flop synchronizer. Every bit goes through
// the same number of stages so the bus stays mutually aligned.
//   clk, rst  clock and asynchronous active-high reset
//   d         asynchronous input bus
//   q         synchronized bus (loads RESET_VAL while in reset)
module sync_bus #(
  parameter int unsigned   N         = 1,
  parameter int unsigned   STAGES    = 2,
  parameter logic [N-1:0]  RESET_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] d,
  output logic [N-1:0] q
);

  logic [N-1:0] stage [STAGES];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < STAGES; i++) stage[i] <= RESET_VAL;
    end else begin
      stage[0] <= d;
      for (int unsigned i = 1; i < STAGES; i++) stage[i] <= stage[i-1];
    end
  end

  assign q = stage[STAGES-1];

endmodule

// File: rtl/tipi_bus_write_latch.sv
// tipi_bus_write_latch: captures TI-99/4A CPU writes into four registers and
// raises sticky per-register pending flags for the Pi side.
//   clk, reset              clock, asynchronous active-high reset
//   we_n                    TI write strobe (active-low, asynchronous)
//   a_addr..d_addr          decoded register selects (asynchronous)
//   din                     TI data bus (asynchronous)
//   a_q..d_q                latched register contents
//   wr[3:0]                 one-cycle commit pulse per register (bit0 = a)
//   pending[3:0]            written-not-yet-consumed flags
//   ack[3:0]                Pi-side consume, clears matching pending bit
//   err                     one-cycle pulse on a multi-select write
module tipi_bus_write_latch
  import tipi_regs_pkg::*;
#(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we_n,
  input  logic             a_addr,
  input  logic             b_addr,
  input  logic             c_addr,
  input  logic             d_addr,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] a_q,
  output logic [WIDTH-1:0] b_q,
  output logic [WIDTH-1:0] c_q,
  output logic [WIDTH-1:0] d_q,
  output logic [3:0]       wr,
  output logic [3:0]       pending,
  input  logic [3:0]       ack,
  output logic             err
);

  localparam int unsigned BUS_W = WIDTH + NUM_REGS + 1;

  logic [BUS_W-1:0]    sync_q;
  logic                we_s;
  logic [NUM_REGS-1:0] sel_s;
  logic [WIDTH-1:0]    din_s;

  // Strobe idles high, so its synchronizer bit resets to 1.
  sync_bus #(
    .N         (BUS_W),
    .STAGES    (SYNC_STAGES),
    .RESET_VAL ({1'b1, {(BUS_W-1){1'b0}}})
  ) u_sync (
    .clk (clk),
    .rst (reset),
    .d   ({we_n, d_addr, c_addr, b_addr, a_addr, din}),
    .q   (sync_q)
  );

  assign {we_s, sel_s, din_s} = sync_q;

  wr_state_t           state;
  logic [NUM_REGS-1:0] hold_sel;
  logic [WIDTH-1:0]    hold_data;
  logic [WIDTH-1:0]    regs [NUM_REGS];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      hold_sel  <= '0;
      hold_data <= '0;
      for (int unsigned i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      wr        <= '0;
      pending   <= '0;
      err       <= 1'b0;
    end else begin
      wr      <= '0;
      err     <= 1'b0;
      pending <= pending & ~ack;
      case (state)
        IDLE: begin
          if (!we_s) state <= ACTIVE;
        end
        ACTIVE: begin
          // Keep overwriting so the commit uses the last sample before the rise.
          if (!we_s) begin
            hold_sel  <= sel_s;
            hold_data <= din_s;
          end else begin
            state <= COMMIT;
          end
        end
        COMMIT: begin
          state <= IDLE;
          if (count_sel(hold_sel) == 1) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
              if (hold_sel[i]) regs[i] <= hold_data;
            end
            wr      <= hold_sel;
            // Set wins over a simultaneous ack on the same bit.
            pending <= (pending & ~ack) | hold_sel;
          end else if (count_sel(hold_sel) > 1) begin
            err <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign a_q = regs[REG_A];
  assign b_q = regs[REG_B];
  assign c_q = regs[REG_C];
  assign d_q = regs[REG_D];

endmodule

// File: tb/tb_tipi_bus_write_latch.sv
module tb_tipi_bus_write_latch;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         we_n;
  logic         a_addr, b_addr, c_addr, d_addr;
  logic [W-1:0] din;
  logic [W-1:0] a_q, b_q, c_q, d_q;
  logic [3:0]   wr;
  logic [3:0]   pending;
  logic [3:0]   ack;
  logic         err;

  int checks = 0;
  int errors = 0;
  int wr_cnt [4];
  int err_cnt = 0;

  always #5 clk = ~clk;

  tipi_bus_write_latch #(
    .WIDTH       (W),
    .SYNC_STAGES (2)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .we_n    (we_n),
    .a_addr  (a_addr),
    .b_addr  (b_addr),
    .c_addr  (c_addr),
    .d_addr  (d_addr),
    .din     (din),
    .a_q     (a_q),
    .b_q     (b_q),
    .c_q     (c_q),
    .d_q     (d_q),
    .wr      (wr),
    .pending (pending),
    .ack     (ack),
    .err     (err)
  );

  // Pulse counters sampled away from the active edge.
  always @(negedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 4; i++) if (wr[i]) wr_cnt[i]++;
      if (err) err_cnt++;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    // Inline-style comparison body shared only for line formatting is avoided;
    // each test below compares directly.
  endtask

  task automatic strobe(input logic [3:0] sel, input logic [W-1:0] data,
                        input int low, input int high);
    @(negedge clk);
    {d_addr, c_addr, b_addr, a_addr} = sel;
    din  = data;
    we_n = 1'b0;
    repeat (low) @(negedge clk);
    we_n = 1'b1;
    repeat (high) @(negedge clk);
  endtask

  task automatic test_reset;
    reset = 1'b1; we_n = 1'b1; ack = '0; din = '0;
    {d_addr, c_addr, b_addr, a_addr} = 4'b0000;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({a_q, b_q, c_q, d_q} !== 32'h0) begin
      errors++; $display("FAIL reset_q: got %h expected 00000000", {a_q, b_q, c_q, d_q});
    end
    checks++;
    if ({pending, wr, err} !== 9'b0) begin
      errors++; $display("FAIL reset_flags: pending=%b wr=%b err=%b expected 0000 0000 0", pending, wr, err);
    end
  endtask

  task automatic test_single_write;
    @(negedge clk);
    b_addr = 1'b1; din = 8'h5A; we_n = 1'b0;
    repeat (4) @(negedge clk);
    we_n = 1'b1;
    repeat (3) @(posedge clk);   // edges 1..3 after the rise
    #1;
    checks++;
    if (b_q !== 8'h00 || wr !== 4'b0000) begin
      errors++; $display("FAIL single_early: b_q=%h wr=%b expected 00 0000", b_q, wr);
    end
    @(posedge clk); #1;          // edge SYNC_STAGES+2
    checks++;
    if (b_q !== 8'h5A) begin
      errors++; $display("FAIL single_bq: got %h expected 5a", b_q);
    end
    checks++;
    if (wr !== 4'b0010 || pending !== 4'b0010) begin
      errors++; $display("FAIL single_flags: wr=%b pending=%b expected 0010 0010", wr, pending);
    end
    checks++;
    if ({a_q, c_q, d_q} !== 24'h0) begin
      errors++; $display("FAIL single_others: got %h expected 000000", {a_q, c_q, d_q});
    end
    @(posedge clk); #1;
    checks++;
    if (wr !== 4'b0000) begin
      errors++; $display("FAIL single_wr_width: got %b expected 0000", wr);
    end
    @(negedge clk);
    b_addr = 1'b0;
  endtask

  task automatic test_back_to_back;
    int base [4];
    for (int i = 0; i < 4; i++) base[i] = wr_cnt[i];
    strobe(4'b0001, 8'hAA, 3, 2);
    strobe(4'b0010, 8'hBB, 3, 2);
    strobe(4'b0100, 8'hCC, 3, 2);
    strobe(4'b1000, 8'hDD, 3, 2);
    {d_addr, c_addr, b_addr, a_addr} = 4'b0000;
    repeat (6) @(negedge clk);
    checks++;
    if ({a_q, b_q, c_q, d_q} !== 32'hAABBCCDD) begin
      errors++; $display("FAIL b2b_q: got %h expected aabbccdd", {a_q, b_q, c_q, d_q});
    end
    checks++;
    if (pending !== 4'b1111) begin
      errors++; $display("FAIL b2b_pending: got %b expected 1111", pending);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (wr_cnt[i] - base[i] !== 1) begin
        errors++; $display("FAIL b2b_wr_count%0d: got %0d expected 1", i, wr_cnt[i] - base[i]);
      end
    end
    ack = 4'b0101;
    @(negedge clk);
    ack = 4'b0000;
    @(negedge clk);
    checks++;
    if (pending !== 4'b1010) begin
      errors++; $display("FAIL ack_clear: got %b expected 1010", pending);
    end
  endtask

  task automatic test_err_and_nosel;
    int e0, w0;
    e0 = err_cnt;
    w0 = wr_cnt[0] + wr_cnt[1] + wr_cnt[2] + wr_cnt[3];
    strobe(4'b0101, 8'h33, 4, 6);
    checks++;
    if (err_cnt - e0 !== 1) begin
      errors++; $display("FAIL multi_err: pulses=%0d expected 1", err_cnt - e0);
    end
    checks++;
    if ({a_q, b_q, c_q, d_q} !== 32'hAABBCCDD || pending !== 4'b1010) begin
      errors++; $display("FAIL multi_nochange: q=%h pending=%b expected aabbccdd 1010", {a_q, b_q, c_q, d_q}, pending);
    end
    strobe(4'b0000, 8'h44, 4, 6);
    checks++;
    if (err_cnt - e0 !== 1 || (wr_cnt[0] + wr_cnt[1] + wr_cnt[2] + wr_cnt[3]) - w0 !== 0) begin
      errors++; $display("FAIL nosel: err pulses=%0d wr pulses=%0d expected 1 0", err_cnt - e0,
                         (wr_cnt[0] + wr_cnt[1] + wr_cnt[2] + wr_cnt[3]) - w0);
    end
    checks++;
    if ({a_q, b_q, c_q, d_q} !== 32'hAABBCCDD || pending !== 4'b1010) begin
      errors++; $display("FAIL nosel_nochange: q=%h pending=%b expected aabbccdd 1010", {a_q, b_q, c_q, d_q}, pending);
    end
  endtask

  task automatic test_ack_collision;
    @(negedge clk);
    d_addr = 1'b1; din = 8'h77; we_n = 1'b0;
    repeat (4) @(negedge clk);
    we_n = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    ack = 4'b1000;               // present at the commit edge
    @(posedge clk); #1;
    checks++;
    if (d_q !== 8'h77 || pending !== 4'b1010) begin
      errors++; $display("FAIL ack_collision: d_q=%h pending=%b expected 77 1010", d_q, pending);
    end
    @(negedge clk);
    ack = 4'b0001;               // bit 0 already clear
    d_addr = 1'b0;
    @(negedge clk);
    ack = 4'b0000;
    @(negedge clk);
    checks++;
    if (pending !== 4'b1010) begin
      errors++; $display("FAIL ack_clear_bit: got %b expected 1010", pending);
    end
  endtask

  task automatic test_reset_midwrite;
    @(negedge clk);
    c_addr = 1'b1; din = 8'h99; we_n = 1'b0;
    repeat (4) @(negedge clk);   // FSM is in ACTIVE by now
    reset = 1'b1;
    #1;
    checks++;
    if (c_q !== 8'h00 || pending !== 4'b0000 || {a_q, b_q, d_q} !== 24'h0) begin
      errors++; $display("FAIL reset_async: c_q=%h pending=%b others=%h expected 00 0000 000000",
                         c_q, pending, {a_q, b_q, d_q});
    end
    din = 8'h11;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    we_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (c_q !== 8'h11 || pending !== 4'b0100 || wr !== 4'b0100) begin
      errors++; $display("FAIL reset_recommit: c_q=%h pending=%b wr=%b expected 11 0100 0100", c_q, pending, wr);
    end
    @(negedge clk);
    c_addr = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 4; i++) wr_cnt[i] = 0;
    test_reset;
    test_single_write;
    test_back_to_back;
    test_err_and_nosel;
    test_ack_collision;
    test_reset_midwrite;
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tipi_bus_write_latch.md
# tipi_bus_write_latch

Write-side companion to the TI-bus read-back mux. Captures TI-99/4A CPU writes into four 8-bit registers (a, b, c, d) in the local clock domain, and raises per-register pending flags for the Raspberry Pi side. Sits between the asynchronous TI bus decode (select lines, data, write strobe) and the Pi-facing register interface.

## Interface
- `WIDTH`, 8, data and register width
- `SYNC_STAGES`, 2, flip-flop stages on every asynchronous bus input (minimum 2)

- `clk`  in  1  system clock
- `reset`  in  1  asynchronous, active-high reset
- `we_n`  in  1  TI write strobe, active-low, asynchronous
- `a_addr`, `b_addr`, `c_addr`, `d_addr`  in  1 each  decoded register selects, active-high, asynchronous
- `din`  in  WIDTH  TI data bus, asynchronous
- `a_q`, `b_q`, `c_q`, `d_q`  out  WIDTH each  latched register contents
- `wr`  out  4  one-cycle commit pulse per register: bit0=a … bit3=d
- `pending`  out  4  sticky "written, not yet consumed" flag per register
- `ack`  in  4  Pi-side consume; clears the matching `pending` bit
- `err`  out  1  one-cycle pulse when a write had more than one select asserted

## Operation
- `we_n`, the four selects and `din` all pass through the same `SYNC_STAGES`-deep synchronizer, so they stay mutually aligned. The synchronized strobe is `we_s`.
- Reset values: all `*_q` = 0, `wr` = 0, `pending` = 0, `err` = 0, FSM in IDLE.
- The FSM has three states: IDLE, ACTIVE, COMMIT.
  - IDLE -> ACTIVE when `we_s` = 0.
  - ACTIVE: on every cycle with `we_s` = 0, capture the synchronized selects and data into holding registers. ACTIVE -> COMMIT when `we_s` = 1.
  - COMMIT: act on the held value (last sample taken while strobe was low), then go to IDLE unconditionally.
- Held selects at COMMIT:
  - Exactly one select set: write held data to that register, pulse its `wr` bit, set its `pending` bit.
  - No select set: no write, no pulse. This is a write to an unrelated address.
  - Two or more selects set: no register changes, pulse `err`.
- `ack[i]` clears `pending[i]` on the next edge.
  - `ack[i]` in the same cycle as a commit to register i: set wins, so `pending[i]` stays 1.
  - `ack` on a bit that is already clear has no effect.
- A write to a register that is already pending overwrites the data. `pending` stays 1; there is no overflow flag.
- `reset` asserted at any time, including ACTIVE or COMMIT: everything returns to reset values immediately and the in-flight write is discarded. After reset deasserts, if `we_s` is still low, the FSM re-enters ACTIVE. The write then commits normally, using the last samples taken after reset.

## Timing
- Latency: `*_q`, `wr` and `pending` update on the 2nd edge after `we_s` first reads 1. That is `SYNC_STAGES`+2 edges after the first edge that samples `we_n` = 1 at the pin.
- `wr` and `err` are high for exactly one cycle per strobe.
- At most one commit per `we_n` low pulse.
- Requirements on the bus:
  - `we_n` low for at least `SYNC_STAGES`+1 clock periods.
  - `we_n` high for at least 2 clock periods between writes.
  - `din` and selects stable from 1 clock period before the `we_n` rising edge until 1 period after it.
- Back-to-back strobes meeting these minimums must each commit. None may be merged.
- All outputs are registered. There is no combinational path from any input to any output.

## Structure
- Package `tipi_regs_pkg`:
  - constants `NUM_REGS` = 4, `REG_A`..`REG_D` = 0..3
  - FSM state enum (IDLE, ACTIVE, COMMIT)
- Sub-module `sync_bus`: parameterized N-bit, `SYNC_STAGES`-deep synchronizer, reset to all ones for `we_n` and all zeros otherwise. Instantiated once over {`we_n`, selects, `din`}.
- The top level holds the FSM, the holding registers, the four data registers and the pending logic.

## Test plan
- Reset, then check idle outputs -> all `*_q` = 00, `pending` = 0000, `wr` = 0000, `err` = 0.
- `b_addr` = 1, `din` = 8'h5A, `we_n` low for 4 clocks then high -> `b_q` = 5A after exactly `SYNC_STAGES`+2 edges; `wr` = 0010 for one cycle; `pending` = 0010; a, c, d unchanged.
- Sequential writes of AA/BB/CC/DD to a/b/c/d, minimum spacing -> each `*_q` holds its value, `pending` = 1111. Then `ack` = 0101 for one cycle -> `pending` = 1010.
- Write with `a_addr` = `c_addr` = 1, `din` = 8'h33 -> `err` pulses once; no `q`, `wr` or `pending` change. Write with no select -> no output change.
- `pending[3]` = 1; commit a new write to d (8'h77) in the same cycle as `ack` = 1000 -> `d_q` = 77, `pending[3]` remains 1.
- Assert `reset` while the FSM is in ACTIVE during a write to c -> `c_q` = 00, `pending` = 0000 immediately. Release reset while `we_n` is still low, with `din` = 8'h11 -> commit of 11 to c on `we_n` rise.
